ahb_req_master: RTL and testbench

Single-transfer AHB-lite master that turns the cache-style request port (rd_en/wr_en, word address, lane-positioned data, byte mask, busy) into AHB-lite NONSEQ/SINGLE transfers. It is the initiator counterpart of the team's AHB-lite SRAM/cache slave. It lets a simple requester, such as a boot loader, a debug port or a DMA helper, reach any slave on the example SoC bus. It handles one outstanding transfer at a time, waits on hready and reports hresp errors back to the requester.

---
 rtl/ahb_req_master.sv | 150 +++++++++++++++
 tb/tb_ahb_req_master.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ahb_req_master.sv
// ahb_req_master: single-outstanding AHB-lite master bridging a rd/wr/mask request port to NONSEQ/SINGLE transfers
// Optional stall watchdog enabled by defining AHB_REQ_MASTER_TIMEOUT_EN.
module ahb_req_master #(
    parameter int W_ADDR         = 32,
    parameter int W_DATA         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rd_en,
    input  logic              i_wr_en,
    input  logic [W_ADDR-1:0] i_addr,
    input  logic [W_DATA-1:0] i_data,
    input  logic [3:0]        i_mask,
    output logic [W_DATA-1:0] o_data,
    output logic              o_valid,
    output logic              o_err,
    output logic              o_busy,
    output logic              o_timeout,
    output logic [W_ADDR-1:0] ahbm_haddr,
    output logic              ahbm_hwrite,
    output logic [1:0]        ahbm_htrans,
    output logic [2:0]        ahbm_hsize,
    output logic [2:0]        ahbm_hburst,
    output logic [3:0]        ahbm_hprot,
    output logic              ahbm_hmastlock,
    output logic [W_DATA-1:0] ahbm_hwdata,
    input  logic              ahbm_hready,
    input  logic              ahbm_hresp,
    input  logic [W_DATA-1:0] ahbm_hrdata
);
    typedef enum logic [1:0] {IDLE, APHASE, DPHASE, ERR2} state_t;
    state_t state_q, state_d;
    logic [W_ADDR-1:0] addr_q, addr_d;
    logic [W_DATA-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [2:0] size_q, size_d, dec_size;
    logic [1:0] dec_lo;
    logic write_q, write_d, valid_q, valid_d, err_q, err_d, dec_ok;

    // mask decode, request acceptance and transfer sequencing
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        dec_ok   = 1'b1;
        dec_lo   = 2'b00;
        dec_size = 3'd0;
        case (i_mask)
            4'b0001: dec_lo = 2'b00;
            4'b0010: dec_lo = 2'b01;
            4'b0100: dec_lo = 2'b10;
            4'b1000: dec_lo = 2'b11;
            4'b0011: dec_size = 3'd1;
            4'b1100: begin dec_size = 3'd1; dec_lo = 2'b10; end
            4'b1111: dec_size = 3'd2;
            default: dec_ok = 1'b0;
        endcase
        case (state_q)
            IDLE: if (i_rd_en || i_wr_en) begin
                if (dec_ok && !(i_rd_en && i_wr_en)) begin
                    state_d     = APHASE;
                    addr_d      = i_addr;
                    addr_d[1:0] = dec_lo;
                    size_d      = dec_size;
                    write_d     = i_wr_en;
                    wdata_d     = i_data;
                end else begin
                    err_d = 1'b1;
                end
            end
            APHASE: state_d = ahbm_hready ? DPHASE : APHASE;
            DPHASE: if (ahbm_hresp) begin
                state_d = ahbm_hready ? IDLE : ERR2;
                err_d   = ahbm_hready;
            end else if (ahbm_hready) begin
                state_d = IDLE;
                valid_d = 1'b1;
                rdata_d = write_q ? rdata_q : ahbm_hrdata;
            end
            ERR2: if (ahbm_hready) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and latched transfer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef AHB_REQ_MASTER_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        timeout_q;
    logic        stall;
    assign stall = (state_q == APHASE || state_q == DPHASE) && !ahbm_hready;
    // saturating count of consecutive stalled cycles; sticky flag once threshold is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= stall ? ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1) : 16'd0;
            if (stall && (32'(cnt_q) + 32'd1 >= 32'(TIMEOUT_CYCLES)))
                timeout_q <= 1'b1;
        end
    end
    assign o_timeout = timeout_q;
`else
    // watchdog absent: constant 0 (threshold is never negative)
    assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif

    assign o_data         = rdata_q;
    assign o_valid        = valid_q;
    assign o_err          = err_q;
    assign o_busy         = (state_q != IDLE);
    assign ahbm_haddr     = addr_q;
    assign ahbm_hwrite    = write_q;
    assign ahbm_htrans    = (state_q == APHASE) ? 2'b10 : 2'b00;
    assign ahbm_hsize     = size_q;
    assign ahbm_hburst    = 3'b000;
    assign ahbm_hprot     = 4'b0011;
    assign ahbm_hmastlock = 1'b0;
    assign ahbm_hwdata    = wdata_q;
endmodule

// File: tb/tb_ahb_req_master.sv
// tb_ahb_req_master: directed self-checking bench for ahb_req_master
module tb_ahb_req_master;
`ifdef AHB_REQ_MASTER_TIMEOUT_EN
    localparam int TO = 8;
    localparam logic TO_EXP = 1'b1;
`else
    localparam int TO = 1024;
    localparam logic TO_EXP = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic i_rd_en = 0, i_wr_en = 0;
    logic [31:0] i_addr = 0, i_data = 0, ahbm_hrdata = 0;
    logic [3:0] i_mask = 0;
    logic ahbm_hready = 1, ahbm_hresp = 0;
    logic [31:0] o_data, ahbm_haddr, ahbm_hwdata;
    logic o_valid, o_err, o_busy, o_timeout, ahbm_hwrite, ahbm_hmastlock;
    logic [1:0] ahbm_htrans;
    logic [2:0] ahbm_hsize, ahbm_hburst;
    logic [3:0] ahbm_hprot;
    int n_cmp = 0, n_bad = 0;

    ahb_req_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .i_rd_en(i_rd_en), .i_wr_en(i_wr_en), .i_addr(i_addr),
        .i_data(i_data), .i_mask(i_mask), .o_data(o_data), .o_valid(o_valid), .o_err(o_err),
        .o_busy(o_busy), .o_timeout(o_timeout), .ahbm_haddr(ahbm_haddr), .ahbm_hwrite(ahbm_hwrite),
        .ahbm_htrans(ahbm_htrans), .ahbm_hsize(ahbm_hsize), .ahbm_hburst(ahbm_hburst),
        .ahbm_hprot(ahbm_hprot), .ahbm_hmastlock(ahbm_hmastlock), .ahbm_hwdata(ahbm_hwdata),
        .ahbm_hready(ahbm_hready), .ahbm_hresp(ahbm_hresp), .ahbm_hrdata(ahbm_hrdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (ahbm_htrans !== 2'b00 || ahbm_haddr !== 32'h0 || ahbm_hwrite !== 1'b0 || ahbm_hsize !== 3'd0) begin n_bad++; $display("FAIL rst_addr_phase got htrans=%b haddr=%h hwrite=%b hsize=%0d exp 00/0/0/0", ahbm_htrans, ahbm_haddr, ahbm_hwrite, ahbm_hsize); end
        n_cmp++; if (ahbm_hwdata !== 32'h0 || o_data !== 32'h0) begin n_bad++; $display("FAIL rst_data got hwdata=%h o_data=%h exp 0/0", ahbm_hwdata, o_data); end
        n_cmp++; if ({o_valid, o_err, o_busy, o_timeout} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got v/e/b/t=%b exp 0000", {o_valid, o_err, o_busy, o_timeout}); end
        n_cmp++; if (ahbm_hburst !== 3'b000 || ahbm_hprot !== 4'b0011 || ahbm_hmastlock !== 1'b0) begin n_bad++; $display("FAIL rst_const got hburst=%b hprot=%b hmastlock=%b exp 000/0011/0", ahbm_hburst, ahbm_hprot, ahbm_hmastlock); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_word;
        i_rd_en = 1; i_addr = 32'h80000104; i_mask = 4'b1111; ahbm_hready = 1; ahbm_hrdata = 32'hDEADBEEF;
        tick();
        i_rd_en = 0; i_addr = 32'h0; i_mask = 4'b0000;
        n_cmp++; if (ahbm_htrans !== 2'b10 || ahbm_haddr !== 32'h80000104 || ahbm_hsize !== 3'd2 || ahbm_hwrite !== 1'b0) begin n_bad++; $display("FAIL rd_aphase got htrans=%b haddr=%h hsize=%0d hwrite=%b exp 10/80000104/2/0", ahbm_htrans, ahbm_haddr, ahbm_hsize, ahbm_hwrite); end
        tick();
        n_cmp++; if (ahbm_htrans !== 2'b00 || o_busy !== 1'b1 || o_valid !== 1'b0) begin n_bad++; $display("FAIL rd_dphase got htrans=%b busy=%b valid=%b exp 00/1/0", ahbm_htrans, o_busy, o_valid); end
        tick();
        n_cmp++; if (o_valid !== 1'b1 || o_data !== 32'hDEADBEEF || o_busy !== 1'b0 || o_err !== 1'b0) begin n_bad++; $display("FAIL rd_done got valid=%b data=%h busy=%b err=%b exp 1/deadbeef/0/0", o_valid, o_data, o_busy, o_err); end
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rd_pulse got valid=%b exp 0", o_valid); end
    endtask

    task automatic test_byte_write;
        i_wr_en = 1; i_addr = 32'h80000010; i_mask = 4'b0100; i_data = 32'h00AB0000; ahbm_hrdata = 32'h11111111;
        tick();
        i_wr_en = 0; i_data = 32'hFFFFFFFF; i_mask = 4'b1111;
        n_cmp++; if (ahbm_htrans !== 2'b10 || ahbm_haddr !== 32'h80000012 || ahbm_hsize !== 3'd0 || ahbm_hwrite !== 1'b1) begin n_bad++; $display("FAIL wr_aphase got htrans=%b haddr=%h hsize=%0d hwrite=%b exp 10/80000012/0/1", ahbm_htrans, ahbm_haddr, ahbm_hsize, ahbm_hwrite); end
        tick();
        n_cmp++; if (ahbm_hwdata !== 32'h00AB0000 || ahbm_htrans !== 2'b00) begin n_bad++; $display("FAIL wr_dphase got hwdata=%h htrans=%b exp 00ab0000/00", ahbm_hwdata, ahbm_htrans); end
        tick();
        n_cmp++; if (o_valid !== 1'b1 || o_busy !== 1'b0 || o_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_done got valid=%b busy=%b data=%h exp 1/0/deadbeef", o_valid, o_busy, o_data); end
        tick();
    endtask

    task automatic test_wait_states;
        i_rd_en = 1; i_addr = 32'h00000041; i_mask = 4'b1100; ahbm_hrdata = 32'h12345678;
        tick();
        i_rd_en = 0; i_addr = 32'hFFFFFFFF;
        for (int c = 1; c <= 8; c++) begin
            ahbm_hready = !(c == 1 || c == 2 || c == 4 || c == 5 || c == 6);
            n_cmp++; if (o_busy !== (c <= 7) || o_valid !== (c == 8)) begin n_bad++; $display("FAIL ws_c%0d got busy=%b valid=%b exp %b/%b", c, o_busy, o_valid, c <= 7, c == 8); end
            if (c <= 3) begin
                n_cmp++; if (ahbm_htrans !== 2'b10 || ahbm_haddr !== 32'h00000042 || ahbm_hsize !== 3'd1 || ahbm_hwrite !== 1'b0) begin n_bad++; $display("FAIL ws_addr_c%0d got htrans=%b haddr=%h hsize=%0d exp 10/00000042/1", c, ahbm_htrans, ahbm_haddr, ahbm_hsize); end
            end
            if (c == 8) begin
                n_cmp++; if (o_data !== 32'h12345678) begin n_bad++; $display("FAIL ws_data got %h exp 12345678", o_data); end
            end
            tick();
        end
        ahbm_hready = 1;
    endtask

    task automatic test_error;
        i_rd_en = 1; i_addr = 32'h00000100; i_mask = 4'b1111; ahbm_hrdata = 32'hCAFEF00D;
        tick();
        i_rd_en = 0;
        tick();
        ahbm_hready = 0; ahbm_hresp = 1;
        tick();
        ahbm_hready = 1; ahbm_hresp = 1;
        n_cmp++; if (o_busy !== 1'b1 || o_err !== 1'b0 || o_valid !== 1'b0 || ahbm_htrans !== 2'b00) begin n_bad++; $display("FAIL err2 got busy=%b err=%b valid=%b htrans=%b exp 1/0/0/00", o_busy, o_err, o_valid, ahbm_htrans); end
        tick();
        ahbm_hresp = 0;
        n_cmp++; if (o_err !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_data !== 32'h12345678) begin n_bad++; $display("FAIL err_done got err=%b valid=%b busy=%b data=%h exp 1/0/0/12345678", o_err, o_valid, o_busy, o_data); end
        tick();
        n_cmp++; if (o_err !== 1'b0 || o_valid !== 1'b0) begin n_bad++; $display("FAIL err_pulse got err=%b valid=%b exp 0/0", o_err, o_valid); end
    endtask

    task automatic test_illegal;
        for (int k = 0; k < 2; k++) begin
            i_rd_en = 1; i_wr_en = (k == 1); i_mask = (k == 0) ? 4'b0110 : 4'b1111; i_addr = 32'h00000200;
            tick();
            i_rd_en = 0; i_wr_en = 0;
            n_cmp++; if (o_err !== 1'b1 || o_busy !== 1'b0 || ahbm_htrans !== 2'b00 || o_valid !== 1'b0) begin n_bad++; $display("FAIL illegal_%0d got err=%b busy=%b htrans=%b valid=%b exp 1/0/00/0", k, o_err, o_busy, ahbm_htrans, o_valid); end
            tick();
            n_cmp++; if (o_err !== 1'b0 || o_busy !== 1'b0 || ahbm_htrans !== 2'b00) begin n_bad++; $display("FAIL illegal_after_%0d got err=%b busy=%b htrans=%b exp 0/0/00", k, o_err, o_busy, ahbm_htrans); end
        end
    endtask

    task automatic test_timeout;
        i_rd_en = 1; i_addr = 32'h00000300; i_mask = 4'b1111; ahbm_hready = 1; ahbm_hrdata = 32'h0BADC0DE;
        tick();
        i_rd_en = 0;
        ahbm_hready = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 8) begin
                n_cmp++; if (o_timeout !== 1'b0) begin n_bad++; $display("FAIL to_early got %b exp 0", o_timeout); end
            end
            if (c == 9) begin
                n_cmp++; if (o_timeout !== TO_EXP) begin n_bad++; $display("FAIL to_rise got %b exp %b", o_timeout, TO_EXP); end
            end
            tick();
        end
        ahbm_hready = 1;
        tick();
        tick();
        n_cmp++; if (o_valid !== 1'b1 || o_data !== 32'h0BADC0DE || o_timeout !== TO_EXP) begin n_bad++; $display("FAIL to_done got valid=%b data=%h timeout=%b exp 1/0badc0de/%b", o_valid, o_data, o_timeout, TO_EXP); end
        tick();
        n_cmp++; if (o_timeout !== TO_EXP) begin n_bad++; $display("FAIL to_sticky got %b exp %b", o_timeout, TO_EXP); end
    endtask

    task automatic test_async_reset;
        i_wr_en = 1; i_addr = 32'h00000400; i_mask = 4'b0011; i_data = 32'h0000BEEF;
        tick();
        i_wr_en = 0;
        n_cmp++; if (ahbm_htrans !== 2'b10 || ahbm_hsize !== 3'd1) begin n_bad++; $display("FAIL ar_aphase got htrans=%b hsize=%0d exp 10/1", ahbm_htrans, ahbm_hsize); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (ahbm_htrans !== 2'b00 || o_busy !== 1'b0 || o_timeout !== 1'b0 || ahbm_haddr !== 32'h0 || o_data !== 32'h0) begin n_bad++; $display("FAIL ar_async got htrans=%b busy=%b timeout=%b haddr=%h data=%h exp 00/0/0/0/0", ahbm_htrans, o_busy, o_timeout, ahbm_haddr, o_data); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_read_word();
        test_byte_write();
        test_wait_states();
        test_error();
        test_illegal();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
